// File: rtl/y86_pkg.sv
// Shared Y86-64 encodings: instruction codes, ALU functions and branch/cmov conditions.
package y86_pkg;

    localparam logic [3:0] I_HALT  = 4'h0;
    localparam logic [3:0] I_NOP   = 4'h1;
    localparam logic [3:0] I_CMOV  = 4'h2;
    localparam logic [3:0] I_IRMOV = 4'h3;
    localparam logic [3:0] I_RMMOV = 4'h4;
    localparam logic [3:0] I_MRMOV = 4'h5;
    localparam logic [3:0] I_OP    = 4'h6;
    localparam logic [3:0] I_JXX   = 4'h7;
    localparam logic [3:0] I_CALL  = 4'h8;
    localparam logic [3:0] I_RET   = 4'h9;
    localparam logic [3:0] I_PUSH  = 4'hA;
    localparam logic [3:0] I_POP   = 4'hB;

    localparam logic [1:0] ALU_ADD = 2'd0;
    localparam logic [1:0] ALU_SUB = 2'd1;
    localparam logic [1:0] ALU_AND = 2'd2;
    localparam logic [1:0] ALU_XOR = 2'd3;

    localparam logic [3:0] C_ALWAYS = 4'd0;
    localparam logic [3:0] C_LE     = 4'd1;
    localparam logic [3:0] C_L      = 4'd2;
    localparam logic [3:0] C_E      = 4'd3;
    localparam logic [3:0] C_NE     = 4'd4;
    localparam logic [3:0] C_GE     = 4'd5;
    localparam logic [3:0] C_G      = 4'd6;

    localparam logic [3:0] OP_IFUN_MAX   = 4'd3;
    localparam logic [3:0] COND_IFUN_MAX = 4'd6;

endpackage

// File: rtl/y86_alu.sv
// Combinational Y86-64 ALU: result = aluB op aluA, plus the flags that result would set.
module y86_alu
    import y86_pkg::*;
#(
    parameter int DATA_W = 64
) (
    input  logic [DATA_W-1:0] aluA,
    input  logic [DATA_W-1:0] aluB,
    input  logic [1:0]        alufun,
    output logic [DATA_W-1:0] result,
    output logic              zf_n,
    output logic              sf_n,
    output logic              of_n
);

    always_comb begin
        result = '0;
        of_n   = 1'b0;
        unique case (alufun)
            ALU_ADD: begin
                result = aluB + aluA;
                of_n   = (aluA[DATA_W-1] == aluB[DATA_W-1]) &&
                         (result[DATA_W-1] != aluB[DATA_W-1]);
            end
            ALU_SUB: begin
                result = aluB - aluA;
                of_n   = (aluA[DATA_W-1] != aluB[DATA_W-1]) &&
                         (result[DATA_W-1] != aluB[DATA_W-1]);
            end
            ALU_AND: result = aluB & aluA;
            ALU_XOR: result = aluB ^ aluA;
            default: result = '0;
        endcase
        zf_n = (result == '0);
        sf_n = result[DATA_W-1];
    end

endmodule

// File: rtl/execute_cc.sv
// SEQ execute stage: operand muxing into the ALU, the {ZF,SF,OF} condition-code register,
// and the cmov/jump condition evaluated from the already-committed CC.
module execute_cc
    import y86_pkg::*;
#(
    parameter int         DATA_W   = 64,
    parameter logic [2:0] CC_RESET = 3'b100
) (
    input  logic              clk,
    input  logic              rst,
    input  logic [3:0]        icode,
    input  logic [3:0]        ifun,
    input  logic [DATA_W-1:0] valA,
    input  logic [DATA_W-1:0] valB,
    input  logic [DATA_W-1:0] valC,
    output logic [DATA_W-1:0] valE,
    output logic              cnd,
    output logic              zf,
    output logic              sf,
    output logic              of,
    output logic              ifun_err
);

    logic [DATA_W-1:0] w_alu_a;
    logic [DATA_W-1:0] w_alu_b;
    logic [1:0]        w_alufun;
    logic [DATA_W-1:0] w_result;
    logic              w_zf_n;
    logic              w_sf_n;
    logic              w_of_n;
    logic              w_op_ok;
    logic              w_sf_xor_of;
    logic [2:0]        r_cc;

    assign w_op_ok = (icode == I_OP) && (ifun <= OP_IFUN_MAX);

    // Stack adjustments reuse the adder: push/call subtract 8, pop/ret add 8.
    always_comb begin
        w_alu_a  = '0;
        w_alu_b  = '0;
        w_alufun = ALU_ADD;
        case (icode)
            I_CMOV:          w_alu_a = valA;
            I_IRMOV:         w_alu_a = valC;
            I_RMMOV, I_MRMOV: begin
                w_alu_a = valC;
                w_alu_b = valB;
            end
            I_OP: begin
                w_alu_a  = valA;
                w_alu_b  = valB;
                w_alufun = ifun[1:0];
            end
            I_CALL, I_PUSH: begin
                w_alu_a  = DATA_W'(8);
                w_alu_b  = valB;
                w_alufun = ALU_SUB;
            end
            I_RET, I_POP: begin
                w_alu_a = DATA_W'(8);
                w_alu_b = valB;
            end
            default: ;
        endcase
    end

    y86_alu #(.DATA_W(DATA_W)) u_alu (
        .aluA   (w_alu_a),
        .aluB   (w_alu_b),
        .alufun (w_alufun),
        .result (w_result),
        .zf_n   (w_zf_n),
        .sf_n   (w_sf_n),
        .of_n   (w_of_n)
    );

    // An OPq with an undefined ifun aliases onto a real ALU function, so its result is masked.
    assign valE = ((icode == I_OP) && !w_op_ok) ? '0 : w_result;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_cc <= CC_RESET;
        end else if (w_op_ok) begin
            r_cc <= {w_zf_n, w_sf_n, w_of_n};
        end
    end

    assign zf = r_cc[2];
    assign sf = r_cc[1];
    assign of = r_cc[0];
    assign w_sf_xor_of = r_cc[1] ^ r_cc[0];

    always_comb begin
        cnd      = 1'b0;
        ifun_err = 1'b0;
        if ((icode == I_CMOV) || (icode == I_JXX)) begin
            case (ifun)
                C_ALWAYS: cnd = 1'b1;
                C_LE:     cnd = w_sf_xor_of | r_cc[2];
                C_L:      cnd = w_sf_xor_of;
                C_E:      cnd = r_cc[2];
                C_NE:     cnd = !r_cc[2];
                C_GE:     cnd = !w_sf_xor_of;
                C_G:      cnd = !w_sf_xor_of && !r_cc[2];
                default:  ifun_err = 1'b1;
            endcase
        end else if ((icode == I_OP) && (ifun > OP_IFUN_MAX)) begin
            ifun_err = 1'b1;
        end
    end

endmodule

// File: tb/tb_execute_cc.sv
// Directed bench for execute_cc: a vector table walked one clock per row, then reset corner cases.
module tb_execute_cc;

    logic        clk;
    logic        rst;
    logic [3:0]  icode;
    logic [3:0]  ifun;
    logic [63:0] valA;
    logic [63:0] valB;
    logic [63:0] valC;
    logic [63:0] valE;
    logic        cnd;
    logic        zf;
    logic        sf;
    logic        of;
    logic        ifun_err;

    int n_checks = 0;
    int n_fail   = 0;

    typedef struct {
        string       name;
        logic [3:0]  icode;
        logic [3:0]  ifun;
        logic [63:0] a;
        logic [63:0] b;
        logic [63:0] c;
        logic [63:0] exp_vale;
        logic        exp_cnd;
        logic        exp_err;
        logic [2:0]  exp_cc;
    } vec_t;

    vec_t       vecs[$];
    logic [2:0] exp_q[$];

    execute_cc #(.DATA_W(64), .CC_RESET(3'b100)) dut (
        .clk      (clk),
        .rst      (rst),
        .icode    (icode),
        .ifun     (ifun),
        .valA     (valA),
        .valB     (valB),
        .valC     (valC),
        .valE     (valE),
        .cnd      (cnd),
        .zf       (zf),
        .sf       (sf),
        .of       (of),
        .ifun_err (ifun_err)
    );

    // clock / reset
    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #100000;
        $display("FAIL timeout: simulation did not finish, got running required done");
        n_fail++;
        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $fatal(1, "timeout");
    end

    // drivers
    task automatic drive(input logic [3:0] ic, input logic [3:0] fn,
                         input logic [63:0] a, input logic [63:0] b, input logic [63:0] c);
        icode = ic;
        ifun  = fn;
        valA  = a;
        valB  = b;
        valC  = c;
    endtask

    task automatic check64(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %h required %h", nm, act, exp);
        end
    endtask

    task automatic check_cc(input string nm, input logic [2:0] exp);
        n_checks++;
        if ({zf, sf, of} !== exp) begin
            n_fail++;
            $display("FAIL %s cc: got zf/sf/of=%b required %b", nm, {zf, sf, of}, exp);
        end
    endtask

    task automatic add(input string nm, input logic [3:0] ic, input logic [3:0] fn,
                       input logic [63:0] a, input logic [63:0] b, input logic [63:0] c,
                       input logic [63:0] ev, input logic ec, input logic ee, input logic [2:0] ecc);
        vec_t v;
        v.name = nm; v.icode = ic; v.ifun = fn; v.a = a; v.b = b; v.c = c;
        v.exp_vale = ev; v.exp_cnd = ec; v.exp_err = ee; v.exp_cc = ecc;
        vecs.push_back(v);
    endtask

    initial begin
        logic [2:0] exp_cc;

        // Rows run back to back; exp_cc is the CC after that row's clock edge.
        add("je_after_reset", 4'h7, 4'h3, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 3'b100);
        add("add_ovf",        4'h6, 4'h0, 64'h7FFF_FFFF_FFFF_FFFF, 64'h1, 64'h0,
            64'h8000_0000_0000_0000, 1'b0, 1'b0, 3'b011);
        add("jl_after_ovf",   4'h7, 4'h2, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 3'b011);
        add("sub_zero",       4'h6, 4'h1, 64'h5, 64'h5, 64'h0, 64'h0, 1'b0, 1'b0, 3'b100);
        add("cmovne",         4'h2, 4'h4, 64'h1234, 64'h99, 64'h77, 64'h1234, 1'b0, 1'b0, 3'b100);
        add("pushq",          4'hA, 4'h0, 64'h0, 64'h100, 64'h0, 64'hF8, 1'b0, 1'b0, 3'b100);
        add("popq",           4'hB, 4'h0, 64'h0, 64'hF8, 64'h0, 64'h100, 1'b0, 1'b0, 3'b100);
        add("mrmovq_wrap",    4'h5, 4'h0, 64'h0, 64'h10, 64'hFFFF_FFFF_FFFF_FFF8, 64'h8, 1'b0, 1'b0, 3'b100);
        add("op_bad_ifun",    4'h6, 4'h5, 64'h3, 64'h4, 64'h0, 64'h0, 1'b0, 1'b1, 3'b100);
        add("sub_neg",        4'h6, 4'h1, 64'h1, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFFF, 1'b0, 1'b0, 3'b010);
        add("jle",            4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 3'b010);
        add("cmovge",         4'h2, 4'h5, 64'hAA, 64'h0, 64'h0, 64'hAA, 1'b0, 1'b0, 3'b010);
        add("jg",             4'h7, 4'h6, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 3'b010);
        add("jxx_bad_ifun",   4'h7, 4'h7, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b1, 3'b010);
        add("cmov_bad_ifun",  4'h2, 4'hF, 64'h5, 64'h0, 64'h0, 64'h5, 1'b0, 1'b1, 3'b010);
        add("rrmovq",         4'h2, 4'h0, 64'h5, 64'h0, 64'h0, 64'h5, 1'b1, 1'b0, 3'b010);
        add("jne",            4'h7, 4'h4, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 3'b010);
        add("irmovq",         4'h3, 4'h0, 64'h1, 64'h2, 64'hDEAD, 64'hDEAD, 1'b0, 1'b0, 3'b010);
        add("rmmovq",         4'h4, 4'h0, 64'h1, 64'h20, 64'h8, 64'h28, 1'b0, 1'b0, 3'b010);
        add("call_wrap",      4'h8, 4'h0, 64'h0, 64'h0, 64'h0, 64'hFFFF_FFFF_FFFF_FFF8, 1'b0, 1'b0, 3'b010);
        add("ret",            4'h9, 4'h0, 64'h0, 64'h40, 64'h0, 64'h48, 1'b0, 1'b0, 3'b010);
        add("sub_ovf",        4'h6, 4'h1, 64'h8000_0000_0000_0000, 64'h0, 64'h0,
            64'h8000_0000_0000_0000, 1'b0, 1'b0, 3'b011);
        add("jge_ovf",        4'h7, 4'h5, 64'h0, 64'h0, 64'h0, 64'h0, 1'b1, 1'b0, 3'b011);
        add("and",            4'h6, 4'h2, 64'hFF00, 64'h0F0F, 64'h0, 64'h0F00, 1'b0, 1'b0, 3'b000);
        add("jle_clear",      4'h7, 4'h1, 64'h0, 64'h0, 64'h0, 64'h0, 1'b0, 1'b0, 3'b000);
        add("halt",           4'h0, 4'h3, 64'h1, 64'h2, 64'h3, 64'h0, 1'b0, 1'b0, 3'b000);
        add("nop",            4'h1, 4'h0, 64'h1, 64'h2, 64'h3, 64'h0, 1'b0, 1'b0, 3'b000);
        add("undef_icode",    4'hC, 4'h7, 64'h1, 64'h2, 64'h3, 64'h0, 1'b0, 1'b0, 3'b000);
        add("xor_sign",       4'h6, 4'h3, 64'h8000_0000_0000_0000, 64'h0, 64'h0,
            64'h8000_0000_0000_0000, 1'b0, 1'b0, 3'b010);

        drive(4'h3, 4'h0, 64'h0, 64'h0, 64'h55);
        rst = 1'b1;
        #1;
        check_cc("reset", 3'b100);
        check64("valE_during_reset", valE, 64'h55);
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;

        foreach (vecs[i]) begin
            drive(vecs[i].icode, vecs[i].ifun, vecs[i].a, vecs[i].b, vecs[i].c);
            exp_q.push_back(vecs[i].exp_cc);
            #1;
            check64({vecs[i].name, " valE"}, valE, vecs[i].exp_vale);
            check64({vecs[i].name, " cnd"}, 64'(cnd), 64'(vecs[i].exp_cnd));
            check64({vecs[i].name, " ifun_err"}, 64'(ifun_err), 64'(vecs[i].exp_err));
            @(posedge clk);
            #1;
            exp_cc = exp_q.pop_front();
            check_cc(vecs[i].name, exp_cc);
            @(negedge clk);
        end

        // Mid-cycle reset clears CC with no clock edge involved.
        drive(4'h1, 4'h0, 64'h0, 64'h0, 64'h0);
        #2;
        rst = 1'b1;
        #1;
        check_cc("rst_midcycle", 3'b100);
        // An OPq edge while reset is held must not load flags.
        drive(4'h6, 4'h3, 64'h8000_0000_0000_0000, 64'h0, 64'h0);
        @(posedge clk);
        #1;
        check_cc("rst_held_edge", 3'b100);
        check64("xor_valE_in_reset", valE, 64'h8000_0000_0000_0000);
        @(negedge clk);
        rst = 1'b0;
        @(posedge clk);
        #1;
        check_cc("xor_after_rst", 3'b010);
        @(negedge clk);
        drive(4'h7, 4'h2, 64'h0, 64'h0, 64'h0);
        #1;
        check64("jl_after_xor", 64'(cnd), 64'h1);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule

// File: doc/execute_cc.md
Name: execute_cc

Overview:
- SEQ execute stage. Sits between decode_writeback (supplies valA/valB) and the memory stage / writeback (consume valE, cnd).
- Computes valE with the ALU for every instruction class.
- Holds the architectural condition-code register (ZF, SF, OF).
- Evaluates the branch/cmov condition cnd from the CC state committed by earlier instructions.

Parameters:
- DATA_W, 64, datapath width. Fixed at 64 for Y86-64; any other value is unsupported.
- CC_RESET, 3'b100, reset value of {ZF,SF,OF}.

Ports:
- clk  input  1  stage clock; CC updates on rising edge
- rst  input  1  asynchronous, active-high reset
- icode  input  4  instruction code from fetch
- ifun  input  4  function code from fetch
- valA  input  64  operand A from decode
- valB  input  64  operand B from decode
- valC  input  64  immediate/displacement from fetch
- valE  output  64  ALU result to memory and writeback
- cnd  output  1  condition result for cmovXX/jXX
- zf  output  1  current ZF
- sf  output  1  current SF
- of  output  1  current OF
- ifun_err  output  1  high when icode=OPq/jXX/cmovXX carries an ifun outside its defined range

Behaviour:
- Reset: while rst is high, {zf,sf,of}=CC_RESET (ZF=1, SF=0, OF=0), asynchronously and independent of clk.
- Reset has no effect on the combinational outputs valE, cnd, ifun_err.
- Reset asserted mid-cycle clears CC immediately; a clk edge while rst is high does not update CC.
- valE is combinational, zero cycles of latency. All arithmetic is modulo 2^64 and unsigned-wrap.
- valE per icode:
  - 2 cmovXX: valA+0
  - 3 irmovq: valC+0
  - 4 rmmovq, 5 mrmovq: valB+valC
  - 6 OPq: valB op valA
  - 8 call, A pushq: valB-8
  - 9 ret, B popq: valB+8
  - 0, 1, 7 and undefined icodes: 0
- OPq ifun encoding: 0 add (valB+valA), 1 sub (valB-valA), 2 and, 3 xor.
- OPq with ifun>3: valE=0, ifun_err=1, CC not updated.
- Flag computation (OPq only), with t = result:
  - ZF = (t==0); SF = t[63].
  - OF for add: (valA[63]==valB[63]) && (t[63]!=valB[63]).
  - OF for sub: (valA[63]!=valB[63]) && (t[63]!=valB[63]).
  - OF = 0 for and/xor.
- CC update: on the rising clk edge, when icode==6 and ifun<=3, {zf,sf,of} <= the new flags. All other icodes hold CC.
- cnd is combinational from the current registered CC, never from the flags being computed this cycle. A jXX immediately after an OPq therefore sees that OPq's flags from the next cycle onward, which matches the SEQ ordering.
- Condition encoding (ifun, for icode 2 or 7):
  - 0 always: 1
  - 1 le: (SF^OF)|ZF
  - 2 l: SF^OF
  - 3 e: ZF
  - 4 ne: !ZF
  - 5 ge: !(SF^OF)
  - 6 g: !(SF^OF)&!ZF
  - ifun>6: cnd=0, ifun_err=1
- For all other icodes, cnd=0.
- ifun_err is 0 for every other icode.
- Back-to-back OPq: each edge commits that cycle's flags. No hazard logic is needed; this is single-cycle SEQ.

Decomposition:
- Shared package y86_pkg holds:
  - icode constants (I_HALT, I_NOP, I_CMOV, I_IRMOV, I_RMMOV, I_MRMOV, I_OP, I_JXX, I_CALL, I_RET, I_PUSH, I_POP)
  - ALU function constants (ALU_ADD, ALU_SUB, ALU_AND, ALU_XOR)
  - condition constants (C_ALWAYS … C_G)
- One sub-module, y86_alu: combinational. Inputs aluA, aluB, alufun. Outputs result, zf_n, sf_n, of_n.
- execute_cc owns operand muxing, the CC register and the condition evaluator.

Test Plan:
- Reset, then icode=7 ifun=3 (je) -> cnd=1; zf=1, sf=0, of=0.
- OPq add with valA=0x7FFF_FFFF_FFFF_FFFF, valB=1 -> valE=0x8000_0000_0000_0000. After the edge: zf=0, sf=1, of=1. Next cycle jl (ifun 2) -> cnd=0.
- OPq sub with valA=5, valB=5 -> valE=0. After the edge: zf=1. Then cmov ifun=4 (ne) -> cnd=0, valE=valA.
- pushq with valB=0x100 -> valE=0xF8. popq with valB=0xF8 -> valE=0x100. CC unchanged across both edges.
- mrmovq with valB=0x10, valC=0xFFFF_FFFF_FFFF_FFF8 -> valE=0x8 (wrap). OPq ifun=5 -> valE=0, ifun_err=1, CC held.
- OPq xor setting sf=1, then rst pulsed between edges -> flags return to 1/0/0 immediately, before the next clk.
